delay: RTL and testbench

//   Fixed-latency pipeline delay line for one 10-bit pixel/coefficient stream
//   (gauss_A path of the real-time figure-recognition pipeline). Realigns the

---
 rtl/delay.sv | 49 ++++
 tb/tb_delay.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay.sv
`default_nettype none
// ============================================================================
// Module      : delay
// Description : Fixed-latency, clock-enabled register delay line for the
//               gauss_A channel. It aligns that channel with sibling channels
//               that are DEPTH stages deeper. Data passes through bit-exact.
// Revision    : 1.0 - initial release
// ============================================================================
module delay #(
    parameter int WIDTH = 10,   // sample width
    parameter int DEPTH = 8     // delay in enabled cycles, legal range 1..64
) (
    input  logic             clk,
    input  logic             rst_n,       // asynchronous, active-low reset
    input  logic             per_clken,   // 1 = shift, 0 = hold every stage
    input  logic             aclr,        // asynchronous, active-high clear
    input  logic [WIDTH-1:0] gauss_A_in,
    output logic [WIDTH-1:0] delay_8x
);

    // Both clear sources are merged into one active-low asynchronous reset
    // net, so every flop has a single reset pin. Either source alone clears.
    logic clear_n;
    assign clear_n = rst_n & ~aclr;

    // stage[0] holds the newest sample and stage[DEPTH-1] the oldest.
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the chain on enabled edges and hold otherwise. A clear empties
    // every stage immediately, so in-flight samples are discarded.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (per_clken) begin
            stage[0] <= gauss_A_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // The output comes straight from the last flop. There is no combinational
    // path from the input to the output.
    assign delay_8x = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay
// Description : Directed and randomised self-checking bench for delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             per_clken = 1'b0;
    logic             aclr      = 1'b0;
    logic [WIDTH-1:0] din       = '0;
    wire  [WIDTH-1:0] dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    delay #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .per_clken  (per_clken),
        .aclr       (aclr),
        .gauss_A_in (din),
        .delay_8x   (dout)
    );

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse aclr between edges. Call this about 1 ns after an edge.
    task automatic clear_pipe();
        aclr = 1'b1;
        #1;
        aclr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int exp;
        per_clken = 1'b1;
        din       = 10'h3FF;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dout !== 10'd0) begin
            fails++;
            $display("FAIL reset_async: got %0d expected 0", dout);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (dout !== 10'd0) begin
                fails++;
                $display("FAIL reset_held[%0d]: got %0d expected 0", k, dout);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            din = 10'(i);
            tick();
            exp = (i >= DEPTH - 1) ? i - (DEPTH - 1) : 0;
            tests++;
            if (dout !== 10'(exp)) begin
                fails++;
                $display("FAIL reset_ramp[%0d]: got %0d expected %0d", i, dout, exp);
            end
        end
    endtask

    task automatic test_wrap();
        int hist [700];
        int n;
        int v;
        int exp;
        clear_pipe();
        per_clken = 1'b1;
        n = 0;
        for (int k = 0; k < 672; k++) begin
            v       = (k <= 640) ? k : k - 641;
            din     = 10'(v);
            hist[n] = v;
            tick();
            exp = (n >= DEPTH - 1) ? hist[n-(DEPTH-1)] : 0;
            tests++;
            if (dout !== 10'(exp)) begin
                fails++;
                $display("FAIL wrap[%0d]: got %0d expected %0d", n, dout, exp);
            end
            n++;
        end
    endtask

    task automatic test_hold();
        int m;
        int exp;
        int held;
        clear_pipe();
        per_clken = 1'b1;
        m    = 0;
        held = 0;
        for (int k = 0; k < 12; k++) begin
            din = 10'(100 + m);
            tick();
            exp = (m >= DEPTH - 1) ? 100 + m - (DEPTH - 1) : 0;
            tests++;
            if (dout !== 10'(exp)) begin
                fails++;
                $display("FAIL hold_pre[%0d]: got %0d expected %0d", m, dout, exp);
            end
            held = exp;
            m++;
        end
        per_clken = 1'b0;
        for (int j = 0; j < 5; j++) begin
            din = 10'(900 + j);
            tick();
            tests++;
            if (dout !== 10'(held)) begin
                fails++;
                $display("FAIL hold_frozen[%0d]: got %0d expected %0d", j, dout, held);
            end
        end
        per_clken = 1'b1;
        for (int k = 0; k < 12; k++) begin
            din = 10'(100 + m);
            tick();
            exp = 100 + m - (DEPTH - 1);
            tests++;
            if (dout !== 10'(exp)) begin
                fails++;
                $display("FAIL hold_resume[%0d]: got %0d expected %0d", m, dout, exp);
            end
            m++;
        end
    endtask

    // use_rst = 0 clears with aclr, use_rst = 1 clears with rst_n.
    task automatic test_clear(input bit use_rst, input int base);
        int exp;
        clear_pipe();
        per_clken = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din = 10'(base + i);
            tick();
        end
        tests++;
        if (dout !== 10'(base + 4)) begin
            fails++;
            $display("FAIL clr_pre[%0d]: got %0d expected %0d", use_rst, dout, base + 4);
        end
        // Clear while enable is low. The output still drops at once.
        per_clken = 1'b0;
        if (use_rst) rst_n = 1'b0; else aclr = 1'b1;
        #1;
        tests++;
        if (dout !== 10'd0) begin
            fails++;
            $display("FAIL clr_noen[%0d]: got %0d expected 0", use_rst, dout);
        end
        rst_n = 1'b1;
        aclr  = 1'b0;
        per_clken = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din = 10'(base + 50 + i);
            tick();
        end
        // Clear with enable high, held across an edge with input 0x3FF.
        if (use_rst) rst_n = 1'b0; else aclr = 1'b1;
        #1;
        tests++;
        if (dout !== 10'd0) begin
            fails++;
            $display("FAIL clr_async[%0d]: got %0d expected 0", use_rst, dout);
        end
        din = 10'h3FF;
        tick();
        tests++;
        if (dout !== 10'd0) begin
            fails++;
            $display("FAIL clr_held[%0d]: got %0d expected 0", use_rst, dout);
        end
        rst_n = 1'b1;
        aclr  = 1'b0;
        for (int j = 0; j < 12; j++) begin
            din = 10'(500 + j);
            tick();
            exp = (j >= DEPTH - 1) ? 500 + j - (DEPTH - 1) : 0;
            tests++;
            if (dout !== 10'(exp)) begin
                fails++;
                $display("FAIL clr_post[%0d][%0d]: got %0d expected %0d", use_rst, j, dout, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] d;
        logic             en;
        clear_pipe();
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back('0);
        for (int c = 0; c < 10000; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            d         = WIDTH'($urandom);
            per_clken = en;
            din       = d;
            tick();
            if (en) begin
                q.push_back(d);
                void'(q.pop_front());
            end
            tests++;
            if (dout !== q[0]) begin
                fails++;
                $display("FAIL random[%0d]: got %0d expected %0d", c, dout, q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hold();
        test_clear(1'b0, 200);
        test_clear(1'b1, 300);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
